// File: rtl/clause_loader_pkg.sv
// -----------------------------------------------------------------------------
// sat_pkg
// Definitions shared by the clause loader and the clause comparator:
//   - default formula geometry (variable ID width, literals per clause,
//     clauses per memory word)
//   - the packed literal type {neg, var_id}
//   - LIT_WIDTH and slot_offset(), which locate a literal slot inside a
//     packed clause-memory word
// -----------------------------------------------------------------------------
package sat_pkg;

    localparam int unsigned VAR_ID_BITS_DEF           = 8;
    localparam int unsigned NUM_VARS_PER_CLAUSE_DEF   = 3;
    localparam int unsigned NUM_CLAUSES_PER_CYCLE_DEF = 16;

    localparam int unsigned LIT_WIDTH = VAR_ID_BITS_DEF + 1;

    // var_id 0 is the empty/pad value, so an all-zero literal never matches.
    typedef struct packed {
        logic                       neg;
        logic [VAR_ID_BITS_DEF-1:0] var_id;
    } lit_t;

    // Bit offset of slot 'slot' in a word whose literals are 'lit_width' wide.
    function automatic int unsigned slot_offset(input int unsigned slot,
                                                input int unsigned lit_width);
        return slot * lit_width;
    endfunction

endpackage

// File: rtl/clause_loader_if.sv
// -----------------------------------------------------------------------------
// clause_loader_if
// Literal stream into the clause loader (valid/ready handshake).
//   lit_valid   master -> slave  literal present
//   lit_ready   slave  -> master literal accepted when valid && ready
//   lit_var_id  master -> slave  variable ID (0 reserved as pad)
//   lit_neg     master -> slave  1 = negated literal
//   lit_last    master -> slave  final literal of the formula
// -----------------------------------------------------------------------------
interface clause_loader_if #(
    parameter int unsigned VAR_ID_BITS = sat_pkg::VAR_ID_BITS_DEF
);
    logic                   lit_valid;
    logic                   lit_ready;
    logic [VAR_ID_BITS-1:0] lit_var_id;
    logic                   lit_neg;
    logic                   lit_last;

    modport master (
        output lit_valid, lit_var_id, lit_neg, lit_last,
        input  lit_ready
    );

    modport slave (
        input  lit_valid, lit_var_id, lit_neg, lit_last,
        output lit_ready
    );
endinterface

// File: rtl/clause_loader.sv
// -----------------------------------------------------------------------------
// clause_loader
// Packs a literal stream into clause-memory words (NUM_VARS_PER_CLAUSE
// literals per clause, NUM_CLAUSES_PER_CYCLE clauses per word) and writes each
// completed word to the next address. Runs once per formula before solving.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           one-cycle pulse: clear all state and begin a load
//   lit             literal stream (clause_loader_if.slave)
//   mem_we          one-cycle write strobe (registered)
//   mem_addr        word address (registered)
//   mem_wdata       packed word (registered)
//   done            load complete, held until the next start
//   clause_count    complete clauses accepted
//   err_overflow    sticky: literal arrived after memory was full
//   err_align       sticky: lit_last arrived mid-clause
// -----------------------------------------------------------------------------
module clause_loader
    import sat_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES           = 64,
    parameter int unsigned VAR_ID_BITS           = VAR_ID_BITS_DEF,
    parameter int unsigned NUM_CLAUSES_PER_CYCLE = NUM_CLAUSES_PER_CYCLE_DEF,
    parameter int unsigned NUM_VARS_PER_CLAUSE   = NUM_VARS_PER_CLAUSE_DEF,
    localparam int unsigned LIT_W        = VAR_ID_BITS + 1,
    localparam int unsigned SLOTS        = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
    localparam int unsigned MEMORY_WIDTH = LIT_W * SLOTS,
    localparam int unsigned NUM_WORDS    = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
    localparam int unsigned ADDR_BITS    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int unsigned CNT_BITS     = $clog2(NUM_CLAUSES + 1)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    clause_loader_if.slave          lit,
    output logic                    mem_we,
    output logic [ADDR_BITS-1:0]    mem_addr,
    output logic [MEMORY_WIDTH-1:0] mem_wdata,
    output logic                    done,
    output logic [CNT_BITS-1:0]     clause_count,
    output logic                    err_overflow,
    output logic                    err_align
);

    localparam int unsigned SLOT_BITS = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned K_BITS    = (NUM_VARS_PER_CLAUSE > 1) ? $clog2(NUM_VARS_PER_CLAUSE) : 1;
    localparam int unsigned WC_BITS   = ADDR_BITS + 1;

    localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(SLOTS - 1);
    localparam logic [K_BITS-1:0]    K_LAST    = K_BITS'(NUM_VARS_PER_CLAUSE - 1);
    localparam logic [WC_BITS-1:0]   WORDS_MAX = WC_BITS'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_e;

    state_e                  state_q;
    logic [MEMORY_WIDTH-1:0] staging_q;
    logic [SLOT_BITS-1:0]    slot_idx_q;
    logic [K_BITS-1:0]       k_q;          // literal position within the current clause
    logic [WC_BITS-1:0]      word_cnt_q;   // words written so far, reaches NUM_WORDS
    logic                    mem_we_q;
    logic [ADDR_BITS-1:0]    mem_addr_q;
    logic [MEMORY_WIDTH-1:0] mem_wdata_q;
    logic                    done_q;
    logic [CNT_BITS-1:0]     clause_count_q;
    logic                    err_overflow_q;
    logic                    err_align_q;

    logic [MEMORY_WIDTH-1:0] word_fill;    // staging word with the incoming literal placed
    logic                    full;

    assign full = (word_cnt_q == WORDS_MAX);

    always_comb begin
        word_fill = staging_q;
        word_fill[slot_offset(32'(slot_idx_q), LIT_W) +: LIT_W] = {lit.lit_neg, lit.lit_var_id};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            staging_q      <= '0;
            slot_idx_q     <= '0;
            k_q            <= '0;
            word_cnt_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            done_q         <= 1'b0;
            clause_count_q <= '0;
            err_overflow_q <= 1'b0;
            err_align_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (start) begin
                state_q        <= LOAD;
                staging_q      <= '0;
                slot_idx_q     <= '0;
                k_q            <= '0;
                word_cnt_q     <= '0;
                done_q         <= 1'b0;
                clause_count_q <= '0;
                err_overflow_q <= 1'b0;
                err_align_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE, DONE: ;
                    LOAD: begin
                        if (lit.lit_valid) begin
                            if (full) begin
                                err_overflow_q <= 1'b1;
                            end else begin
                                if (k_q == K_LAST) begin
                                    k_q            <= '0;
                                    clause_count_q <= clause_count_q + 1'b1;
                                end else begin
                                    k_q <= k_q + 1'b1;
                                    if (lit.lit_last) err_align_q <= 1'b1;
                                end
                                // The final partial word is written on the lit_last
                                // accept itself, so the strobe lands in FLUSH and a
                                // word completed by lit_last is written only once.
                                if (lit.lit_last || slot_idx_q == SLOT_LAST) begin
                                    mem_we_q    <= 1'b1;
                                    mem_addr_q  <= word_cnt_q[ADDR_BITS-1:0];
                                    mem_wdata_q <= word_fill;
                                    staging_q   <= '0;
                                    slot_idx_q  <= '0;
                                    word_cnt_q  <= word_cnt_q + 1'b1;
                                end else begin
                                    staging_q  <= word_fill;
                                    slot_idx_q <= slot_idx_q + 1'b1;
                                end
                            end
                            if (lit.lit_last) state_q <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign lit.lit_ready  = (state_q == LOAD);
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign done           = done_q;
    assign clause_count   = clause_count_q;
    assign err_overflow   = err_overflow_q;
    assign err_align      = err_align_q;

endmodule

// File: doc/clause_loader.md
# clause_loader

Writes the clause database into clause memory in the packed word format the comparator reads. Accepts a stream of literals over a valid/ready handshake and packs NUM_VARS_PER_CLAUSE literals per clause and NUM_CLAUSES_PER_CYCLE clauses per word. Each completed word is written to the next memory address. It sits between the host/formula-input path and the clause RAM, and runs once per formula before the solve phase.

## Interface
- NUM_CLAUSES, 64, max clauses in the formula
- VAR_ID_BITS, 8, variable ID width; ID 0 is reserved as the empty/pad value
- NUM_CLAUSES_PER_CYCLE, 16, clauses per memory word
- NUM_VARS_PER_CLAUSE, 3, literals per clause
- MEMORY_WIDTH, derived (VAR_ID_BITS+1)*NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE, 432 by default
- SLOTS, derived NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE, 48 by default
- NUM_WORDS, derived NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE, 4 by default
- ADDR_BITS, derived max(1, $clog2(NUM_WORDS))

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; clears all state and begins a load
- lit_valid  in  1  literal present
- lit_ready  out  1  literal accepted when lit_valid && lit_ready
- lit_var_id  in  VAR_ID_BITS  variable ID
- lit_neg  in  1  1 = negated literal
- lit_last  in  1  marks the final literal of the formula
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_BITS  word address
- mem_wdata  out  MEMORY_WIDTH  packed word
- done  out  1  load complete; held until the next start
- clause_count  out  $clog2(NUM_CLAUSES+1)  clauses accepted, excluding discarded clauses
- err_overflow  out  1  sticky: a literal arrived after memory was full
- err_align  out  1  sticky: lit_last arrived on a non-clause boundary

## Operation
- Slot s (0..SLOTS-1) = clause c*NUM_VARS_PER_CLAUSE + literal k. The slot is stored at mem_wdata[s*(VAR_ID_BITS+1) +: VAR_ID_BITS+1] = {lit_neg, lit_var_id}. Slot s maps to comparator bitmask bit s.
- Unwritten slots are all-zero (var_id 0), so they never match an assignment.
- FSM states:
  - IDLE: lit_ready=0; start → LOAD.
  - LOAD: lit_ready=1. Each accept writes the staging slot and increments slot_idx.
    - Accepting slot SLOTS-1: the staging word is copied to the mem_wdata register, the write is scheduled, staging is zeroed and word_addr increments. An accept in the following cycle goes to slot 0 of the cleared staging; there are no bubbles.
    - Accept with lit_last → FLUSH.
  - FLUSH: lit_ready=0. mem_we=1 if the final word is non-empty, then → DONE.
  - DONE: lit_ready=0, done=1; start → LOAD.
- Final word: a partially filled staging word is written padded with zeros. If lit_last completes a word exactly, exactly one write occurs for it.
- clause_count increments on acceptance of each literal with k=NUM_VARS_PER_CLAUSE-1.
- Full: once NUM_WORDS words have been written, lit_ready stays 1. Further literals are accepted and discarded, and err_overflow is set. No further write occurs; lit_last still → FLUSH (mem_we=0) → DONE.
- Misaligned lit_last (k≠NUM_VARS_PER_CLAUSE-1): err_align is set, the partial clause is written as-is (trailing slots 0), and clause_count is not incremented.
- start in any state, including mid-LOAD: the staging word, slot_idx, word_addr, clause_count and errors are cleared, and the state goes to LOAD. A pending partial word is discarded and not written.

## Timing
- Reset values: lit_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, clause_count=0, err_overflow=0, err_align=0, state IDLE.
- mem_we, mem_addr and mem_wdata are registered. mem_we pulses for exactly one cycle, the cycle after the accept that completed the word or carried lit_last.
- mem_addr/mem_wdata are stable while mem_we=1.
- done rises the cycle after FLUSH, which is 2 cycles after the lit_last accept.
- Throughput is 1 literal/cycle. Gaps in lit_valid do not change the memory image.
- rst_n low mid-load aborts with no write and returns to the reset values.
- start and rst_n low in the same cycle: reset wins.

## Structure
- Shared package `sat_pkg`:
  - VAR_ID_BITS, NUM_VARS_PER_CLAUSE and NUM_CLAUSES_PER_CYCLE defaults.
  - Literal typedef {neg, var_id}.
  - LIT_WIDTH and the slot-offset function, shared with comparator.
- Single module, no sub-modules. The FSM enum is local to the module.

## Test plan
- start; literals (5,neg),(7,pos),(9,neg, last) → one write at addr 0:
  - mem_wdata[8:0]=9'h105, [17:9]=9'h007, [26:18]=9'h109, rest 0.
  - clause_count=1; done 2 cycles after the last accept.
- 192 literals with continuous valid (var_id = index%255+1, last on the 192nd):
  - 4 writes, addr 0..3, each one cycle after slot 47 is accepted.
  - lit_ready never drops during LOAD; clause_count=64; no errors.
- 195 literals (last on the 195th):
  - 4 writes only; err_overflow=1; clause_count=64; done asserted.
- lit_last on the 2nd literal (3,pos),(4,neg):
  - err_align=1; one write with slots 0..1 = 9'h003, 9'h104 and all else 0.
  - clause_count=0.
- 20 literals, then start, then 3 literals with last:
  - Single write at addr 0 containing only the new clause; clause_count=1.
- 20 literals, then rst_n low for one cycle:
  - No mem_we; all outputs at reset values; lit_ready=0 until start.
